// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART: register map, STATUS bit positions,
// reset divisor and the state encoding used by both serial FSMs.
package uart_pkg;

   // Register addresses on the 8-bit APB address bus
   localparam logic [7:0] ADDR_RXDATA = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_TXDATA = 8'h02;
   localparam logic [7:0] ADDR_DIVLO  = 8'h03;
   localparam logic [7:0] ADDR_DIVHI  = 8'h04;
   localparam logic [7:0] ADDR_CTRL   = 8'h05;

   // STATUS register bit positions
   localparam int ST_RX_AVAIL  = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_TX_FULL   = 2;
   localparam int ST_TX_EMPTY  = 3;
   localparam int ST_TX_BUSY   = 4;
   localparam int ST_OVERRUN   = 5;
   localparam int ST_FRAME_ERR = 6;

   // 115200 baud with 16x oversampling from a 100 MHz clock
   localparam int DEFAULT_DIV = 54;

   // Frame states, shared by the receiver and the transmitter
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both the RX and TX byte queues.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head word is presented combinationally; the consumer captures it on
// the same edge that pops it. A push into a full FIFO only succeeds when a
// pop happens in the same cycle; a pop from an empty FIFO is ignored.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int D_W   = 8,
   parameter int DEPTH = 64
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  logic [D_W-1:0] wdata_i,
   input  logic           pop_i,
   output logic [D_W-1:0] head_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic [D_W-1:0] mem_q [DEPTH];
   logic           do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; both advance modulo DEPTH via the wrap bit
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate reads
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_apb_top.sv
// APB-attached UART: baud tick generator, 16x-oversampling receiver,
// transmitter, two byte FIFOs and the APB register decode.
// Optional feature macro: UART_LOOPBACK_EN adds CTRL (0x05) bit0, which
// feeds the receiver from the internal transmit line instead of the pin.
//
// APB handshake: zero wait states. PREADY = PSEL & PENABLE. Read data is
// captured during the setup phase (PSEL & !PENABLE) and held until the next
// read; writes, FIFO pops and STATUS clears take effect on the single clock
// edge that ends the first cycle of PSEL & PENABLE.
module uart_apb_top
   import uart_pkg::*;
#(
   parameter int D_W    = 8,
   parameter int B_TICK = 16,
   parameter int DEPTH  = 64,
   parameter int DIV_W  = 16,
   parameter int APB_DW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_data,
   input  logic              tx_start,
   output logic              tx_data,
   input  logic [7:0]        PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [APB_DW-1:0] PWDATA,
   output logic              PREADY,
   output logic [APB_DW-1:0] PRDATA
);

   localparam int TC_W = $clog2(B_TICK);
   localparam int BC_W = $clog2(D_W);

   // ---------------- APB access qualification ----------------
   logic acc_q;
   logic access, acc_first, setup_rd, wr_en, rd_commit;

   assign access    = PSEL & PENABLE;
   assign acc_first = access & ~acc_q;
   assign setup_rd  = PSEL & ~PENABLE & ~PWRITE;
   assign wr_en     = acc_first & PWRITE;
   assign rd_commit = acc_first & ~PWRITE;
   assign PREADY    = access;

   // ---------------- Registers ----------------
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0]  div_eff;
   logic              tick, div_wr;
   logic [APB_DW-1:0] prdata_q;
   logic              pop_pend_q, clr_ovr_q, clr_ferr_q;
   logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic              loop_q;

   // RX FIFO
   logic           rx_push, rx_pop, rx_full, rx_empty;
   logic [D_W-1:0] rx_head;
   // TX FIFO
   logic           tx_push, tx_pop, tx_full, tx_empty;
   logic [D_W-1:0] tx_head;

   // ---------------- Baud tick generator ----------------
   assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
   assign tick    = (baud_cnt_q == div_eff - DIV_W'(1));
   assign div_wr  = wr_en && ((PADDR == ADDR_DIVLO) || (PADDR == ADDR_DIVHI));

   // Counter wraps at divisor-1; a divisor write restarts it from zero
   always_comb begin
      baud_cnt_d = baud_cnt_q + DIV_W'(1);
      if (div_wr || tick) baud_cnt_d = '0;
   end

   // Divisor byte writes
   always_comb begin
      div_d = div_q;
      if (wr_en && PADDR == ADDR_DIVLO) div_d[7:0]       = PWDATA[7:0];
      if (wr_en && PADDR == ADDR_DIVHI) div_d[DIV_W-1:8] = PWDATA[DIV_W-9:0];
   end

   // ---------------- RX input selection and synchronizer ----------------
   logic rx_in, rx_s1_q, rx_s2_q;
   logic tx_q, tx_d;

`ifdef UART_LOOPBACK_EN
   logic loop_d;

   assign rx_in = loop_q ? tx_q : rx_data;

   // Loopback control bit
   always_comb begin
      loop_d = loop_q;
      if (wr_en && PADDR == ADDR_CTRL) loop_d = PWDATA[0];
   end

   // Loopback register
   always_ff @(posedge clk) begin
      if (!rst) loop_q <= 1'b0;
      else      loop_q <= loop_d;
   end
`else
   assign rx_in  = rx_data;
   assign loop_q = 1'b0;
`endif

   // Two-flop synchronizer, reset to the idle-high line level
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_in;
         rx_s2_q <= rx_s1_q;
      end
   end

   // ---------------- RX FSM ----------------
   uart_state_e    rx_state_q, rx_state_d;
   logic [TC_W-1:0] rx_tick_q, rx_tick_d;
   logic [BC_W-1:0] rx_bit_q, rx_bit_d;
   logic [D_W-1:0]  rx_shift_q, rx_shift_d;
   logic            ferr_set, ovr_set;

   // Receiver next state: mid-start check, then one sample per bit period
   always_comb begin
      rx_state_d = rx_state_q;
      rx_tick_d  = rx_tick_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      ferr_set   = 1'b0;
      unique case (rx_state_q)
         S_IDLE: begin
            if (!rx_s2_q) begin
               rx_tick_d  = '0;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_tick_q == TC_W'(B_TICK/2 - 1)) begin
                  rx_tick_d  = '0;
                  rx_bit_d   = '0;
                  rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
               end else begin
                  rx_tick_d = rx_tick_q + TC_W'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (rx_tick_q == TC_W'(B_TICK - 1)) begin
                  rx_tick_d  = '0;
                  rx_shift_d = {rx_s2_q, rx_shift_q[D_W-1:1]};
                  if (rx_bit_q == BC_W'(D_W - 1)) rx_state_d = S_STOP;
                  else                            rx_bit_d   = rx_bit_q + BC_W'(1);
               end else begin
                  rx_tick_d = rx_tick_q + TC_W'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (rx_tick_q == TC_W'(B_TICK - 1)) begin
                  rx_tick_d  = '0;
                  rx_push    = rx_s2_q;
                  ferr_set   = !rx_s2_q;
                  rx_state_d = S_IDLE;
               end else begin
                  rx_tick_d = rx_tick_q + TC_W'(1);
               end
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // Receiver state registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state_q <= S_IDLE;
         rx_tick_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_tick_q  <= rx_tick_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // A byte arriving while full is lost unless a read frees a slot this cycle
   assign ovr_set = rx_push && rx_full && !rx_pop;

   // ---------------- TX FSM ----------------
   uart_state_e    tx_state_q, tx_state_d;
   logic [TC_W-1:0] tx_tick_q, tx_tick_d;
   logic [BC_W-1:0] tx_bit_q, tx_bit_d;
   logic [D_W-1:0]  tx_shift_q;

   // Transmitter next state and next line level
   always_comb begin
      tx_state_d = tx_state_q;
      tx_tick_d  = tx_tick_q;
      tx_bit_d   = tx_bit_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         S_IDLE: begin
            if (tx_start && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_tick_d  = '0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (tx_tick_q == TC_W'(B_TICK - 1)) begin
                  tx_tick_d  = '0;
                  tx_bit_d   = '0;
                  tx_state_d = S_DATA;
               end else begin
                  tx_tick_d = tx_tick_q + TC_W'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tx_tick_q == TC_W'(B_TICK - 1)) begin
                  tx_tick_d = '0;
                  if (tx_bit_q == BC_W'(D_W - 1)) tx_state_d = S_STOP;
                  else                            tx_bit_d   = tx_bit_q + BC_W'(1);
               end else begin
                  tx_tick_d = tx_tick_q + TC_W'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tx_tick_q == TC_W'(B_TICK - 1)) begin
                  tx_tick_d  = '0;
                  tx_state_d = S_IDLE;
               end else begin
                  tx_tick_d = tx_tick_q + TC_W'(1);
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      unique case (tx_state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = tx_shift_q[tx_bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   // Transmitter registers; the popped byte is captured on the pop edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state_q <= S_IDLE;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
         if (tx_pop) tx_shift_q <= tx_head;
         tx_q       <= tx_d;
      end
   end

   assign tx_data = tx_q;

   // ---------------- FIFOs ----------------
   assign rx_pop  = rd_commit && pop_pend_q;
   assign tx_push = wr_en && (PADDR == ADDR_TXDATA);

   uart_fifo #(.D_W(D_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (rx_push),
      .wdata_i (rx_shift_q),
      .pop_i   (rx_pop),
      .head_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   uart_fifo #(.D_W(D_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (tx_push),
      .wdata_i (D_W'(PWDATA)),
      .pop_i   (tx_pop),
      .head_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   // ---------------- STATUS and read mux ----------------
   logic [7:0]        status;
   logic [APB_DW-1:0] rd_val;

   // Assemble STATUS and select the read value for the addressed register
   always_comb begin
      status               = '0;
      status[ST_RX_AVAIL]  = !rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_TX_BUSY]   = (tx_state_q != S_IDLE);
      status[ST_OVERRUN]   = overrun_q;
      status[ST_FRAME_ERR] = frame_err_q;
      rd_val = '0;
      case (PADDR)
         ADDR_RXDATA: rd_val = rx_empty ? '0 : APB_DW'(rx_head);
         ADDR_STATUS: rd_val = APB_DW'(status);
         ADDR_DIVLO:  rd_val = APB_DW'(div_q[7:0]);
         ADDR_DIVHI:  rd_val = APB_DW'(div_q[DIV_W-1:8]);
`ifdef UART_LOOPBACK_EN
         ADDR_CTRL:   rd_val = APB_DW'(loop_q);
`endif
         default:     rd_val = '0;
      endcase
   end

   // Sticky error flags: set wins; a read clears only what it returned
   always_comb begin
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      if (rd_commit && clr_ovr_q)  overrun_d   = 1'b0;
      if (rd_commit && clr_ferr_q) frame_err_d = 1'b0;
      if (ovr_set)                 overrun_d   = 1'b1;
      if (ferr_set)                frame_err_d = 1'b1;
   end

   // APB-side registers: read capture, pending side effects, divisor, flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q       <= 1'b0;
         prdata_q    <= '0;
         pop_pend_q  <= 1'b0;
         clr_ovr_q   <= 1'b0;
         clr_ferr_q  <= 1'b0;
         div_q       <= DIV_W'(DEFAULT_DIV);
         baud_cnt_q  <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         acc_q       <= access;
         if (setup_rd) prdata_q <= rd_val;
         pop_pend_q  <= setup_rd && (PADDR == ADDR_RXDATA) && !rx_empty;
         clr_ovr_q   <= setup_rd && (PADDR == ADDR_STATUS) && overrun_q;
         clr_ferr_q  <= setup_rd && (PADDR == ADDR_STATUS) && frame_err_q;
         div_q       <= div_d;
         baud_cnt_q  <= baud_cnt_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign PRDATA = prdata_q;

endmodule

// File: tb/tb_uart_apb_top.sv
// Bench for uart_apb_top: register-access vector table, then directed
// serial sequences (RX frames, TX frame, framing error, overrun, zero
// divisor, reset mid-frame, and loopback when UART_LOOPBACK_EN is defined).
`timescale 1ns/1ps
module tb_uart_apb_top;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_data;
   logic       tx_start;
   logic       tx_data;
   logic [7:0] PADDR;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PWDATA;
   logic       PREADY;
   logic [7:0] PRDATA;

   int unsigned     tests = 0;
   int unsigned     fails = 0;
   longint unsigned cyc = 0;
   logic [7:0]      exp_q[$];

   uart_apb_top dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .tx_start(tx_start), .tx_data(tx_data),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      @(negedge clk);
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      @(negedge clk);
      PENABLE = 1'b1;
      #1;
      check("pready", PREADY, 1'b1);
      d = PRDATA;
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      apb_read(a, d);
      check(name, d, exp);
   endtask

   // Drive one serial frame; a bad stop bit is held low for 3/4 of a bit
   task automatic send_rx(input logic [7:0] b, input int bit_ns, input logic stop_ok);
      rx_data = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx_data = b[i];
         #(bit_ns);
      end
      if (stop_ok) begin
         rx_data = 1'b1;
         #(bit_ns);
      end else begin
         rx_data = 1'b0;
         #(bit_ns * 3 / 4);
         rx_data = 1'b1;
         #(bit_ns * 2);
      end
   endtask

   task automatic wait_cyc(input longint unsigned target);
      while (cyc < target) @(negedge clk);
   endtask

   // ---------------- register vector table ----------------
   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[20];

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] d;
      logic       fall_seen;
      longint unsigned t0;
      logic [7:0] tx_byte;
      logic       exp_bit;

      rst = 1'b0; rx_data = 1'b1; tx_start = 1'b0;
      PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;

      vecs[0]  = '{1'b0, ADDR_STATUS, 8'h00, 8'h08, "rst_status"};
      vecs[1]  = '{1'b0, ADDR_DIVLO,  8'h00, 8'd54, "rst_divlo"};
      vecs[2]  = '{1'b0, ADDR_DIVHI,  8'h00, 8'h00, "rst_divhi"};
      vecs[3]  = '{1'b0, ADDR_RXDATA, 8'h00, 8'h00, "rxdata_empty"};
      vecs[4]  = '{1'b0, 8'h06,       8'h00, 8'h00, "unmapped_rd"};
      vecs[5]  = '{1'b0, ADDR_CTRL,   8'h00, 8'h00, "rst_ctrl"};
      vecs[6]  = '{1'b1, ADDR_DIVLO,  8'h12, 8'h00, "wr_divlo"};
      vecs[7]  = '{1'b0, ADDR_DIVLO,  8'h00, 8'h12, "rb_divlo"};
      vecs[8]  = '{1'b1, ADDR_DIVHI,  8'h34, 8'h00, "wr_divhi"};
      vecs[9]  = '{1'b0, ADDR_DIVHI,  8'h00, 8'h34, "rb_divhi"};
      vecs[10] = '{1'b1, 8'h07,       8'hFF, 8'h00, "wr_unmapped"};
      vecs[11] = '{1'b0, 8'h07,       8'h00, 8'h00, "rb_unmapped"};
      vecs[12] = '{1'b1, ADDR_CTRL,   8'h01, 8'h00, "wr_ctrl"};
`ifdef UART_LOOPBACK_EN
      vecs[13] = '{1'b0, ADDR_CTRL,   8'h00, 8'h01, "rb_ctrl"};
`else
      vecs[13] = '{1'b0, ADDR_CTRL,   8'h00, 8'h00, "rb_ctrl"};
`endif
      vecs[14] = '{1'b1, ADDR_CTRL,   8'h00, 8'h00, "clr_ctrl"};
      vecs[15] = '{1'b1, ADDR_DIVLO,  8'd54, 8'h00, "restore_divlo"};
      vecs[16] = '{1'b1, ADDR_DIVHI,  8'h00, 8'h00, "restore_divhi"};
      vecs[17] = '{1'b0, ADDR_DIVLO,  8'h00, 8'd54, "rb_divlo54"};
      vecs[18] = '{1'b0, ADDR_DIVHI,  8'h00, 8'h00, "rb_divhi0"};
      vecs[19] = '{1'b0, ADDR_STATUS, 8'h00, 8'h08, "status_idle"};

      // Reset values
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_pready", PREADY, 1'b0);
      check("rst_prdata", PRDATA, 8'h00);
      check("rst_tx_data", tx_data, 1'b1);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
         else            read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end
      repeat (5) @(negedge clk);
      check("prdata_hold", PRDATA, 8'h08);

      // Two RX frames at the nominal 115200 bit time
      send_rx(8'hD5, 8680, 1'b1);
      send_rx(8'hDF, 8680, 1'b1);
      read_check("rx_status2", ADDR_STATUS, 8'h09);
      read_check("rx_byte0", ADDR_RXDATA, 8'hD5);
      read_check("rx_byte1", ADDR_RXDATA, 8'hDF);
      read_check("rx_byte2_empty", ADDR_RXDATA, 8'h00);
      read_check("rx_status_drained", ADDR_STATUS, 8'h08);

      // TX frame of 0x38 at divisor 54 (864 clocks per bit)
      tx_byte  = 8'h38;
      tx_start = 1'b1;
      apb_write(ADDR_TXDATA, tx_byte);
      fall_seen = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 4 && !fall_seen; i++) begin
         @(negedge clk);
         if (tx_data == 1'b0) begin
            fall_seen = 1'b1;
            t0 = cyc;
         end
      end
      check("tx_start_fall", fall_seen, 1'b1);
      tx_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         wait_cyc(t0 + 432 + longint'(k) * 864);
         @(negedge clk);
         if (k == 0)      exp_bit = 1'b0;
         else if (k == 9) exp_bit = 1'b1;
         else             exp_bit = tx_byte[k-1];
         check($sformatf("tx_bit%0d", k), tx_data, exp_bit);
         if (k == 0) read_check("tx_busy_status", ADDR_STATUS, 8'h18);
      end
      wait_cyc(t0 + 10 * 864 + 100);
      read_check("tx_done_status", ADDR_STATUS, 8'h08);

      // Framing error at divisor 2 (32 clocks per bit)
      apb_write(ADDR_DIVLO, 8'd2);
      send_rx(8'h5A, 320, 1'b0);
      read_check("ferr_status", ADDR_STATUS, 8'h48);
      read_check("ferr_cleared", ADDR_STATUS, 8'h08);
      read_check("ferr_no_push", ADDR_RXDATA, 8'h00);

      // 65 bytes without reading: last one overruns
      for (int i = 0; i < 65; i++) begin
         d = 8'(i * 7 + 3);
         if (i < 64) exp_q.push_back(d);
         send_rx(d, 320, 1'b1);
      end
      read_check("ovr_status", ADDR_STATUS, 8'h2B);
      for (int i = 0; i < 64; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         read_check($sformatf("ovr_rd%0d", i), ADDR_RXDATA, e);
      end
      read_check("ovr_empty", ADDR_RXDATA, 8'h00);
      read_check("ovr_cleared", ADDR_STATUS, 8'h08);

      // Divisor 0 behaves as divisor 1 (16 clocks per bit)
      apb_write(ADDR_DIVLO, 8'd0);
      send_rx(8'h3C, 160, 1'b1);
      read_check("div0_rx", ADDR_RXDATA, 8'h3C);

`ifdef UART_LOOPBACK_EN
      // Loopback: pin held high, TX byte returns through RX
      apb_write(ADDR_DIVLO, 8'd2);
      apb_write(ADDR_CTRL, 8'h01);
      rx_data  = 1'b1;
      tx_start = 1'b1;
      apb_write(ADDR_TXDATA, 8'hA5);
      repeat (450) @(negedge clk);
      tx_start = 1'b0;
      read_check("loop_rx", ADDR_RXDATA, 8'hA5);
      apb_write(ADDR_CTRL, 8'h00);
`endif

      // Reset in the middle of a TX frame
      apb_write(ADDR_DIVLO, 8'd2);
      tx_start = 1'b1;
      apb_write(ADDR_TXDATA, 8'h00);
      repeat (60) @(negedge clk);
      check("tx_mid_low", tx_data, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("tx_after_rst", tx_data, 1'b1);
      tx_start = 1'b0;
      rst = 1'b1;
      read_check("post_rst_status", ADDR_STATUS, 8'h08);
      read_check("post_rst_divlo", ADDR_DIVLO, 8'd54);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_apb_top.md
# uart_apb_top

APB-attached UART with a 16x-oversampling receiver, a transmitter, and 64-entry RX and TX FIFOs. It sits between a serial line pair and an 8-bit APB bus. The APB slave exposes the FIFOs, a status register and a programmable baud divisor.

## Interface
- D_W, 8: data bits per frame (LSB first, 1 start, 1 stop, no parity).
- B_TICK, 16: oversampling ticks per bit.
- DEPTH, 64: entries per FIFO (power of two).
- DIV_W, 16: baud divisor width.
- APB_DW, 8: APB data width.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-low.
- rx_data  in  1  serial receive line, idle high.
- tx_start  in  1  transmit enable, level-sensitive.
- tx_data  out  1  serial transmit line, idle high.
- PADDR  in  8  register address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  APB_DW  write data.
- PREADY  out  1  transfer complete.
- PRDATA  out  APB_DW  read data.

## Operation
- Register map:
  - 0x00 RXDATA (R): pops the RX FIFO. Returns 0x00 when empty; no pop occurs.
  - 0x01 STATUS (R): bit0 rx_avail, bit1 rx_full, bit2 tx_full, bit3 tx_empty, bit4 tx_busy, bit5 overrun, bit6 frame_err. Reading clears bits 5–6.
  - 0x02 TXDATA (W): pushes PWDATA into the TX FIFO. Dropped when full.
  - 0x03 DIVLO (R/W) and 0x04 DIVHI (R/W): baud divisor. Reset value is 54 (115200 baud at 100 MHz).
  - All other addresses read 0; writes to them are ignored.
- Baud generator: counter from 0 to divisor-1. It emits a one-cycle tick on wrap; tick period = divisor clocks. A divisor of 0 is treated as 1. Writing either divisor byte restarts the counter.
- RX path:
  - rx_data passes through a 2-flop synchronizer.
  - FSM states IDLE, START, DATA, STOP.
  - IDLE→START on a low level.
  - START: after B_TICK/2 ticks, go to DATA if the line is still low; otherwise return to IDLE (glitch rejection).
  - DATA: sample every B_TICK ticks, shifting LSB first, for D_W bits.
  - STOP: sample after B_TICK ticks.
    - Stop=1: push the byte.
    - Stop=0: discard the byte and set frame_err.
    - Either way, return to IDLE.
  - Push with the RX FIFO full: byte dropped, overrun set.
- TX path:
  - FSM states IDLE, START, DATA, STOP.
  - In IDLE, with tx_start=1 and the TX FIFO non-empty: pop one byte, then drive start, D_W data bits (LSB first), then stop.
  - Each bit lasts B_TICK ticks.
  - tx_busy=1 outside IDLE.
  - Deasserting tx_start mid-frame completes the current frame.
- FIFOs: synchronous, with first-word read data registered at pop.
  - Simultaneous push and pop when full: the pop is honoured and the push succeeds.
  - Simultaneous push and pop when empty: the push only.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - tx_data=1, PREADY=0, PRDATA=0.
  - FIFOs empty, flags 0, divisor 54, both FSMs IDLE.
- Reset mid-frame aborts the frame. tx_data returns to 1 in the next cycle.
- APB, zero wait states:
  - PREADY=1 combinationally whenever PSEL&PENABLE.
  - Write and pop side effects occur on exactly one clock edge per access phase (the first cycle of PSEL&PENABLE).
  - PRDATA is valid in the access phase and holds its value until the next read.
- RX byte latency: visible as rx_avail one cycle after the stop-bit sample.
- TX: tx_data falls within 2 cycles of tx_start=1 with TX non-empty.
- Frame length = (D_W+2)·B_TICK·divisor clocks.

## Configuration
- UART_LOOPBACK_EN defined:
  - Register 0x05 CTRL bit0 = loopback (R/W, reset 0).
  - When loopback=1, the RX input is taken from the internal tx_data, and the rx_data pin is ignored.
  - tx_data still drives the pin.
- Macro undefined: 0x05 reads 0, writes are ignored, and RX always comes from the pin.

## Structure
- Package uart_pkg holds:
  - Register address localparams (RXDATA, STATUS, TXDATA, DIVLO, DIVHI, CTRL).
  - STATUS bit indices.
  - DEFAULT_DIV=54.
  - The RX/TX FSM state enum.
- Sub-module uart_fifo (parameters D_W and DEPTH) is instantiated twice, once for RX and once for TX.
- The baud generator, both FSMs and the APB decode live in the top.

## Test plan
- Reset, then read STATUS → 0x08 (tx_empty only). Read DIVLO → 54; DIVHI → 0. tx_data = 1.
- Drive RX frames at 8680 ns/bit: 0xD5 then 0xDF. Read 0x00 three times → 0xD5, 0xDF, 0x00. PREADY=1 on each access phase; STATUS bit0 goes to 0 after the second read.
- Write 0x38 (56) to 0x02 with tx_start=1 → tx_data shows start bit, bits 0,0,0,1,1,1,0,0, then stop; 864 clocks per bit.
- Send a frame with stop=0 → nothing is pushed. STATUS bit6 = 1; a second STATUS read shows bit6 = 0.
- Receive 65 bytes without reading → rx_full=1 and overrun=1. The first 64 bytes read back in order.
- With UART_LOOPBACK_EN: set CTRL=1, write 0xA5 → RXDATA returns 0xA5 while the rx_data pin is held high.
